// File: rtl/button_conditioner.sv
// Push-button conditioner: per-lane 2-FF synchroniser, debounce FSM, stable level,
// one-cycle press/release pulses and optional auto-repeat pulses while held.
`timescale 1ns/1ps
module button_conditioner #(
    parameter int              NBTN           = 3,
    parameter int              DEBOUNCE_TICKS = 4,
    parameter int              HOLD_TICKS     = 16,
    parameter int              REPEAT_TICKS   = 8,
    parameter logic [NBTN-1:0] REPEAT_MASK    = NBTN'(3'b010),
    parameter int              CNT_W          = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_in,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] btn_repeat
);

    typedef enum logic [2:0] {
        S_RELEASED,
        S_PRESS_CHK,
        S_PRESSED,
        S_REPEATING,
        S_RELEASE_CHK
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q [NBTN];
    state_t           state_d [NBTN];
    logic [CNT_W-1:0] cnt_q   [NBTN];
    logic [CNT_W-1:0] cnt_d   [NBTN];

    logic [NBTN-1:0] sync1_q, sync1_d;
    logic [NBTN-1:0] sync2_q, sync2_d;
    logic [NBTN-1:0] level_q, level_d;
    logic [NBTN-1:0] press_q, press_d;
    logic [NBTN-1:0] release_q, release_d;
    logic [NBTN-1:0] repeat_q, repeat_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
    end

    // sync2_q is the synchronised level each lane's FSM acts on.
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            repeat_d[i]  = 1'b0;
            case (state_q[i])
                S_RELEASED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_PRESS_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                S_PRESS_CHK: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_RELEASED;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = S_PRESSED;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                S_PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_RELEASE_CHK;
                        cnt_d[i]   = '0;
                    end else if (REPEAT_MASK[i] && (cnt_q[i] == HOLD_LAST)) begin
                        state_d[i]  = S_REPEATING;
                        cnt_d[i]    = '0;
                        repeat_d[i] = 1'b1;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                S_REPEATING: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_RELEASE_CHK;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == REP_LAST) begin
                        cnt_d[i]    = '0;
                        repeat_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                S_RELEASE_CHK: begin
                    // A bounce back high returns to PRESSED without a new press pulse.
                    if (sync2_q[i]) begin
                        state_d[i] = S_PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i]   = S_RELEASED;
                        cnt_d[i]     = '0;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = S_RELEASED;
                    cnt_d[i]   = '0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= S_RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner at default parameters.
`timescale 1ns/1ps
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn_in;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic [2:0] btn_repeat;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        btn_in = 3'b111;
        @(negedge clk);
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_checks++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'h000) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h expected 000", c,
                         {btn_level, btn_press, btn_release, btn_repeat});
            end
        end
        btn_in = 3'b000;
        reset  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_checks++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'h000) begin
                n_fail++;
                $display("[TB] FAIL reset_release cycle %0d: got %h expected 000", c,
                         {btn_level, btn_press, btn_release, btn_repeat});
            end
        end
    endtask

    task automatic test_single_press;
        int press_cyc = -1, press_cnt = 0, level_cyc = -1, rep_cnt = 0;
        int rel_cyc = -1, rel_cnt = 0, fall_cyc = -1;
        btn_in = 3'b001;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (btn_press[0]) begin
                press_cnt++;
                if (press_cyc < 0) press_cyc = c;
            end
            if (btn_level[0] && level_cyc < 0) level_cyc = c;
            if (btn_repeat[0]) rep_cnt++;
        end
        btn_in = 3'b000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (btn_release[0]) begin
                rel_cnt++;
                if (rel_cyc < 0) rel_cyc = c;
            end
            if (!btn_level[0] && fall_cyc < 0) fall_cyc = c;
            if (btn_repeat[0]) rep_cnt++;
        end
        n_checks++;
        if (press_cyc !== 7) begin
            n_fail++;
            $display("[TB] FAIL press0_cycle: got %0d expected 7", press_cyc);
        end
        n_checks++;
        if (press_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL press0_count: got %0d expected 1", press_cnt);
        end
        n_checks++;
        if (level_cyc !== 7) begin
            n_fail++;
            $display("[TB] FAIL level0_rise: got %0d expected 7", level_cyc);
        end
        n_checks++;
        if (rel_cyc !== 7) begin
            n_fail++;
            $display("[TB] FAIL release0_cycle: got %0d expected 7", rel_cyc);
        end
        n_checks++;
        if (rel_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL release0_count: got %0d expected 1", rel_cnt);
        end
        n_checks++;
        if (fall_cyc !== 7) begin
            n_fail++;
            $display("[TB] FAIL level0_fall: got %0d expected 7", fall_cyc);
        end
        n_checks++;
        if (rep_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL repeat0_masked: got %0d expected 0", rep_cnt);
        end
    endtask

    task automatic test_glitch;
        int act = 0, pulses = 0, low_cnt = 0;
        btn_in = 3'b001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (btn_level[0] | btn_press[0] | btn_release[0] | btn_repeat[0]) act++;
        end
        btn_in = 3'b000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (btn_level[0] | btn_press[0] | btn_release[0] | btn_repeat[0]) act++;
        end
        n_checks++;
        if (act !== 0) begin
            n_fail++;
            $display("[TB] FAIL short_press_glitch: got %0d active cycles expected 0", act);
        end
        btn_in = 3'b001;
        for (int c = 1; c <= 10; c++) tick();
        n_checks++;
        if (btn_level[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL glitch_setup_level: got %b expected 1", btn_level[0]);
        end
        btn_in = 3'b000;
        for (int c = 1; c <= 2; c++) begin
            tick();
            if (btn_press[0] | btn_release[0]) pulses++;
            if (!btn_level[0]) low_cnt++;
        end
        btn_in = 3'b001;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (btn_press[0] | btn_release[0]) pulses++;
            if (!btn_level[0]) low_cnt++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("[TB] FAIL low_glitch_pulses: got %0d expected 0", pulses);
        end
        n_checks++;
        if (low_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL low_glitch_level: got %0d low cycles expected 0", low_cnt);
        end
        btn_in = 3'b000;
        for (int c = 1; c <= 12; c++) tick();
        n_checks++;
        if (btn_level[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL glitch_cleanup_level: got %b expected 0", btn_level[0]);
        end
    endtask

    task automatic test_repeat;
        int exp_rep [4] = '{23, 31, 39, 47};
        int rep_cyc [8];
        int rep_cnt = 0, press_cyc = -1, overlap = 0;
        int rel_cnt = 0, rel_cyc = -1, late_rep = 0;
        for (int k = 0; k < 8; k++) rep_cyc[k] = -1;
        btn_in = 3'b010;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (btn_press[1] && press_cyc < 0) press_cyc = c;
            if (btn_repeat[1]) begin
                if (rep_cnt < 8) rep_cyc[rep_cnt] = c;
                rep_cnt++;
            end
            if ((int'(btn_press[1]) + int'(btn_release[1]) + int'(btn_repeat[1])) > 1) overlap++;
        end
        btn_in = 3'b000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (btn_release[1]) begin
                rel_cnt++;
                if (rel_cyc < 0) rel_cyc = c;
            end
            if (btn_repeat[1]) late_rep++;
            if ((int'(btn_press[1]) + int'(btn_release[1]) + int'(btn_repeat[1])) > 1) overlap++;
        end
        n_checks++;
        if (press_cyc !== 7) begin
            n_fail++;
            $display("[TB] FAIL press1_cycle: got %0d expected 7", press_cyc);
        end
        n_checks++;
        if (rep_cnt !== 4) begin
            n_fail++;
            $display("[TB] FAIL repeat1_count: got %0d expected 4", rep_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rep_cyc[k] !== exp_rep[k]) begin
                n_fail++;
                $display("[TB] FAIL repeat1_cycle[%0d]: got %0d expected %0d", k, rep_cyc[k], exp_rep[k]);
            end
        end
        n_checks++;
        if (rel_cnt !== 1 || rel_cyc !== 7) begin
            n_fail++;
            $display("[TB] FAIL release1: got count %0d cycle %0d expected count 1 cycle 7", rel_cnt, rel_cyc);
        end
        n_checks++;
        if (late_rep !== 0 || overlap !== 0) begin
            n_fail++;
            $display("[TB] FAIL repeat1_exclusive: got late %0d overlap %0d expected 0 0", late_rep, overlap);
        end
    endtask

    task automatic test_back_to_back;
        int p0 = -1, p2 = -1, p1_cnt = 0;
        btn_in = 3'b101;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (btn_press[0] && p0 < 0) p0 = c;
            if (btn_press[2] && p2 < 0) p2 = c;
            if (btn_press[1]) p1_cnt++;
        end
        n_checks++;
        if (p0 !== 7 || p2 !== 7) begin
            n_fail++;
            $display("[TB] FAIL simultaneous_press: got lane0 %0d lane2 %0d expected 7 7", p0, p2);
        end
        n_checks++;
        if (p1_cnt !== 0 || btn_level !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL simultaneous_isolation: got lane1 presses %0d level %b expected 0 101",
                     p1_cnt, btn_level);
        end
        btn_in = 3'b000;
        for (int c = 1; c <= 12; c++) tick();
        n_checks++;
        if (btn_level !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL simultaneous_release_level: got %b expected 000", btn_level);
        end
    endtask

    task automatic test_reset_mid_repeat;
        int rep_cnt = 0, press_cyc = -1, press_cnt = 0, rel_cnt = 0, rep_cyc = -1;
        btn_in = 3'b010;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (btn_repeat[1]) rep_cnt++;
        end
        n_checks++;
        if (btn_level[1] !== 1'b1 || rep_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_state: got level %b repeats %0d expected 1 1", btn_level[1], rep_cnt);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'h000) begin
            n_fail++;
            $display("[TB] FAIL async_reset_clear: got %h expected 000",
                     {btn_level, btn_press, btn_release, btn_repeat});
        end
        @(negedge clk);
        n_checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'h000) begin
            n_fail++;
            $display("[TB] FAIL reset_held_clear: got %h expected 000",
                     {btn_level, btn_press, btn_release, btn_repeat});
        end
        reset = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (btn_press[1]) begin
                press_cnt++;
                if (press_cyc < 0) press_cyc = c;
            end
            if (btn_release[1]) rel_cnt++;
            if (btn_repeat[1] && rep_cyc < 0) rep_cyc = c;
        end
        n_checks++;
        if (press_cyc !== 7 || press_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_press: got cycle %0d count %0d expected 7 1", press_cyc, press_cnt);
        end
        n_checks++;
        if (rep_cyc !== 23) begin
            n_fail++;
            $display("[TB] FAIL post_reset_repeat: got %0d expected 23", rep_cyc);
        end
        n_checks++;
        if (rel_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_no_release: got %0d expected 0", rel_cnt);
        end
        btn_in = 3'b000;
        rel_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (btn_release[1]) rel_cnt++;
        end
        n_checks++;
        if (rel_cnt !== 1 || btn_level !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL final_release: got count %0d level %b expected 1 000", rel_cnt, btn_level);
        end
    endtask

    initial begin
        reset  = 1'b0;
        btn_in = 3'b000;
        test_reset();
        test_single_press();
        test_glitch();
        test_repeat();
        test_back_to_back();
        test_reset_mid_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw watch push-buttons (mode-select, increment) before they reach the mode counter and the increment demux.
- Per button: 2-FF synchroniser, debounce state machine, stable level output, and one-cycle press/release pulses.
- Buttons selected by REPEAT_MASK also produce auto-repeat pulses while held, so a time field can be fast-set.
- Runs on the main system clock, upstream of the trigger inputs of the mode counter and increment demux.

Parameters:
- NBTN, 3, number of independent buttons.
- DEBOUNCE_TICKS, 4, consecutive stable synchronised cycles required to accept a press or a release (>=2).
- HOLD_TICKS, 16, cycles a debounced press must be held before the first repeat pulse (>=2).
- REPEAT_TICKS, 8, cycles between subsequent repeat pulses (>=2).
- REPEAT_MASK, 3'b010, bit i=1 enables auto-repeat on button i.
- CNT_W, 16, width of each per-button counter; must hold max(DEBOUNCE_TICKS, HOLD_TICKS, REPEAT_TICKS)-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_in  in  NBTN  raw, asynchronous, bouncy button levels; 1 = pressed.
- btn_level  out  NBTN  debounced level; 1 = pressed.
- btn_press  out  NBTN  one-cycle pulse on an accepted press.
- btn_release  out  NBTN  one-cycle pulse on an accepted release.
- btn_repeat  out  NBTN  one-cycle auto-repeat pulse; always 0 for buttons with REPEAT_MASK bit = 0.

Behaviour:
- Reset (reset=0, asynchronous) clears, in every button lane:
  - both synchroniser flops, the counter and all outputs to 0;
  - the state to RELEASED.
  - All of this holds while reset stays low, regardless of btn_in.
- Synchroniser: two flops per bit. s = second-flop output, which lags btn_in by 2 edges.
- The per-button FSM is registered, and all outputs are registered. Lanes are fully independent; simultaneous activity on several buttons is handled in parallel.
- RELEASED:
  - s=1: go to PRESS_CHK, cnt<=0.
- PRESS_CHK:
  - s=0: go to RELEASED; no pulse.
  - s=1 and cnt==DEBOUNCE_TICKS-1: go to PRESSED, cnt<=0, btn_level<=1, btn_press<=1 for one cycle.
  - Otherwise cnt++.
- PRESSED:
  - s=0: go to RELEASE_CHK, cnt<=0.
  - Repeat-enabled button and cnt==HOLD_TICKS-1: go to REPEATING, cnt<=0, btn_repeat<=1 for one cycle.
  - Otherwise cnt++, saturating at all-ones. The counter never wraps.
- REPEATING:
  - s=0: go to RELEASE_CHK, cnt<=0.
  - cnt==REPEAT_TICKS-1: cnt<=0, btn_repeat<=1 for one cycle.
  - Otherwise cnt++.
- RELEASE_CHK (btn_level stays 1):
  - s=1: go to PRESSED, cnt<=0. No new press pulse. A repeat-enabled button therefore restarts its hold delay.
  - s=0 and cnt==DEBOUNCE_TICKS-1: go to RELEASED, btn_level<=0, btn_release<=1 for one cycle.
  - Otherwise cnt++.
- Latency:
  - btn_in steady high to btn_level/btn_press high = DEBOUNCE_TICKS+3 rising edges (7 at defaults).
  - Release to btn_level low/btn_release high uses the same count.
- btn_press, btn_release and btn_repeat are never asserted together in one lane. The first repeat comes HOLD_TICKS cycles after the press pulse.
- Reset mid-operation:
  - Any state is discarded immediately; no release pulse is produced.
  - If the button is still held after reset deasserts, the lane performs a full new press acceptance with a press pulse.
- Glitches shorter than DEBOUNCE_TICKS synchronised cycles in either direction have no effect on any output.

Test Plan:
- reset=0, btn_in=3'b111 for 20 cycles -> all outputs stay 0. Release reset with btn_in=0 -> outputs remain 0.
- btn_in[0]=1 held for 40 cycles, then 0 ->
  - btn_level[0] rises 7 edges after the rise, with btn_press[0] high for exactly 1 cycle in that same cycle;
  - btn_repeat[0] stays 0 throughout;
  - btn_level[0] falls 7 edges after btn_in falls, with btn_release[0] high for exactly 1 cycle.
- btn_in[0] high for 3 cycles then low, and later a low glitch of 2 cycles while pressed -> no change to btn_level and no pulses.
- btn_in[1] held for 50 cycles, press accepted at cycle L -> btn_repeat[1] pulses at L+16, L+24, L+32, L+40; a single btn_release[1] pulse follows the release.
- btn_in[0] and btn_in[2] rise on the same edge -> both lanes assert btn_press in the same cycle, 7 edges later.
- btn_in[1] held into REPEATING, reset pulsed low for 1 cycle with the button still held -> outputs go to 0 asynchronously with no release pulse. A new btn_press[1] appears 7 edges after reset deasserts; repeats restart at +16.
